// File: rtl/rr_arbiter_hold.sv
// N-way round-robin arbiter with registered one-hot grant and bounded burst hold.
// The owner keeps the grant while requesting, for at most MAX_HOLD consecutive cycles.
module rr_arbiter_hold #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned IDXW     = $clog2(N)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N-1:0]    i_req,
  output logic [N-1:0]    o_grant,
  output logic            o_grant_valid,
  output logic [IDXW-1:0] o_grant_idx,
  output logic            o_grant_new
);

  localparam int unsigned HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HoldLast = HCW'(MAX_HOLD - 1);

  logic [N-1:0]    r_grant;
  logic            r_grant_valid;
  logic [IDXW-1:0] r_grant_idx;
  logic            r_grant_new;
  logic [IDXW-1:0] r_ptr;
  logic [HCW-1:0]  r_hold_cnt;

  logic            w_hold;
  logic            w_found;
  logic [IDXW-1:0] w_winner;
  logic [IDXW-1:0] w_ptr_next;
  logic [N-1:0]    w_onehot;
  int unsigned     w_idx;

  assign w_hold = r_grant_valid && i_req[r_grant_idx] && (r_hold_cnt < HoldLast);

  // Search upward from r_ptr with explicit modulo-N wrap (N need not be a power of 2).
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int unsigned off = 0; off < N; off++) begin
      w_idx = 32'(r_ptr) + off;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && i_req[IDXW'(w_idx)]) begin
        w_found  = 1'b1;
        w_winner = IDXW'(w_idx);
      end
    end
  end

  always_comb begin
    w_onehot           = '0;
    w_onehot[w_winner] = 1'b1;
    w_ptr_next         = (w_winner == IDXW'(N - 1)) ? '0 : w_winner + IDXW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
      r_grant_new   <= 1'b0;
      r_ptr         <= '0;
      r_hold_cnt    <= '0;
    end else if (w_hold) begin
      r_hold_cnt  <= r_hold_cnt + HCW'(1);
      r_grant_new <= 1'b0;
    end else if (w_found) begin
      r_grant       <= w_onehot;
      r_grant_valid <= 1'b1;
      r_grant_idx   <= w_winner;
      r_grant_new   <= 1'b1;
      r_hold_cnt    <= '0;
      r_ptr         <= w_ptr_next;
    end else begin
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
      r_grant_new   <= 1'b0;
      r_hold_cnt    <= '0;
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_valid = r_grant_valid;
  assign o_grant_idx   = r_grant_idx;
  assign o_grant_new   = r_grant_new;

  a_onehot0 : assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(r_grant));
  a_valid_or : assert property (@(posedge i_clk) disable iff (i_rst)
                                r_grant_valid == (|r_grant));
  a_idx_match : assert property (@(posedge i_clk) disable iff (i_rst)
                                 r_grant_valid |-> r_grant[r_grant_idx]);
  a_grant_req : assert property (@(posedge i_clk) !i_rst |=>
                                 ((r_grant & $past(i_req)) == r_grant));

endmodule

// File: doc/rr_arbiter_hold.md
Name: rr_arbiter_hold

Overview:
- Parametrised N-way round-robin arbiter with a registered one-hot grant and bounded grant hold (burst lock).
- Successor to the fixed 4-way rotate/priority/rotate arbiter: generalised requester count, configurable hold limit, encoded grant index and new-grant strobe.
- Sits in front of a shared resource (bus, memory port, FIFO write side) where one requester owns the resource until it drops its request or the hold limit expires.

Parameters:
- N, 4, number of requesters; legal range 2..32.
- MAX_HOLD, 4, max consecutive cycles one owner may hold a grant; legal range 1..255; 1 = pure per-cycle round robin.
- IDXW, $clog2(N), derived width of grant_idx; not overridden by users.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  N  request vector; bit i = requester i wants the resource.
- grant  output  N  registered one-hot grant, or all-zero when idle.
- grant_valid  output  1  registered; equals OR of grant.
- grant_idx  output  IDXW  registered index of the set grant bit; 0 when idle.
- grant_new  output  1  registered one-cycle pulse; the current grant started this cycle, including a re-grant to the same owner after hold expiry.

Behaviour:
- Reset (rst=1 at posedge): grant=0, grant_valid=0, grant_idx=0, grant_new=0, ptr=0, hold_cnt=0. Reset mid-burst drops the grant at that edge with no completion.
- State:
  - ptr (IDXW bits): highest-priority index for the next arbitration.
  - owner: held implicitly in grant/grant_idx.
  - hold_cnt: 0..MAX_HOLD-1, number of cycles the owner has held beyond its first.
- Latency: 1 cycle. req sampled at edge k produces grant visible after edge k.
- Each posedge (rst=0), decide in this order:
  - HOLD: grant_valid=1, req[owner]=1 and hold_cnt<MAX_HOLD-1. Grant unchanged, hold_cnt+1, grant_new=0, ptr unchanged.
  - ARBITRATE: any other case.
    - Search req from ptr upward, wrapping modulo N; the first set bit wins.
    - Winner found: grant=onehot(winner), grant_idx=winner, grant_new=1, hold_cnt=0, ptr=(winner+1) mod N.
    - No req set: grant=0, grant_valid=0, grant_idx=0, grant_new=0, hold_cnt=0, ptr unchanged.
- ptr already points past the current owner, so on hold expiry the owner has lowest priority. It is re-granted only when it is the sole requester; grant_new pulses again in that case.
- Owner drops req: handoff at the next edge with no idle gap, provided another req is set.
- Simultaneous events: owner drops req and others rise in the same cycle. Search starts from ptr, i.e. owner+1.
- Wrap-around: ptr=N-1 with winner N-1 gives ptr=0. Search from ptr=N-1 checks N-1, then 0, 1, and so on.
- Arithmetic: hold_cnt width is $clog2(MAX_HOLD) with a minimum of 1. Compare is unsigned and hold_cnt never exceeds MAX_HOLD-1. ptr increment wraps explicitly for non-power-of-2 N.
- Invariants, checked by assertion:
  - grant is always zero- or one-hot.
  - grant_valid == |grant.
  - grant[grant_idx]==1 whenever grant_valid=1.
  - A granted bit always had req=1 at the deciding edge.
- Fairness: with all N requesting continuously, each requester is granted within (N-1)*MAX_HOLD cycles after losing.
- No combinational path from req to any output.

Test Plan:
- Reset then idle. rst=1 for 2 cycles, req=0 -> all outputs 0. req=4'b0100 -> next cycle grant=4'b0100, grant_idx=2, grant_new=1.
- Hold limit, N=4, MAX_HOLD=4. req[1] held high alone for 10 cycles -> grant=4'b0010 throughout; grant_new pulses on cycles 1, 5, 9.
- Forced rotation, N=4, MAX_HOLD=4, req=4'b1111 constant from reset -> grant sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001...; grant_new every 4th cycle.
- Early release and handoff. Owner 0 with req=4'b0101; drop req[0] after 2 cycles -> next cycle grant=4'b0100, no idle cycle, grant_new=1.
- Non-power-of-2 wrap, N=5, MAX_HOLD=1, req=5'b10001 -> grant alternates 00001, 10000; grant_idx alternates 0, 4; ptr wraps 4->0 correctly.
- Reset mid-burst. Owner 2 at hold_cnt=2, assert rst one cycle with req unchanged (=4'b0100) -> grant=0 during reset; after release grant=4'b0100 again, grant_new=1, hold counts restart from 0.
